// File: rtl/vsa16_dmem_io.sv
// vsa16_dmem_io: data-side memory and I/O stage behind the VSA16 core.
// A word RAM sits at the bottom of the byte address space. A small I/O page
// at IO_BASE holds an output register, a registered input port, a
// free-running timer with compare, and sticky status flags.
//
// Ports:
//   clock     - master clock, rising edge
//   reset     - synchronous, active-high
//   addr      - byte address (core ALUOutput); addr[0] is ignored for decode
//   wdata     - store data (core dataout)
//   wr        - store strobe, asserted in the MEM cycle of SW
//   rdata     - load data, combinational from addr and current state
//   in_port   - external input pins, registered every cycle into IN
//   out_port  - OUT register value
//   timer_irq - STAT.match
//   err       - STAT.misalign
module vsa16_dmem_io #(
  parameter int unsigned RAM_WORDS = 128,
  parameter logic [15:0] IO_BASE   = 16'hFF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        wr,
  output logic [15:0] rdata,
  input  logic [15:0] in_port,
  output logic [15:0] out_port,
  output logic        timer_irq,
  output logic        err
);

  localparam int unsigned AW        = $clog2(RAM_WORDS);
  localparam logic [16:0] RAM_BYTES = 17'(2 * RAM_WORDS);

  // Word offsets (byte offset / 2) within the I/O page.
  typedef enum logic [6:0] {
    REG_OUT  = 7'd0,
    REG_IN   = 7'd1,
    REG_CNT  = 7'd2,
    REG_CMP  = 7'd3,
    REG_STAT = 7'd4
  } reg_e;

  logic [15:0] mem [RAM_WORDS];

  logic [15:0] out_r;
  logic [15:0] in_r;
  logic [15:0] cnt;
  logic [15:0] cmp;
  logic        match;
  logic        misalign;

  logic          ram_hit;
  logic          io_hit;
  logic [6:0]    io_off;
  logic [AW-1:0] ram_idx;
  logic          aligned_wr;
  logic          misaligned_wr;
  logic          wr_out;
  logic          wr_cnt;
  logic          wr_cmp;
  logic          wr_stat;
  logic          wr_ram;

  assign ram_hit = ({1'b0, addr} < RAM_BYTES);
  assign io_hit  = (addr[15:8] == IO_BASE[15:8]);
  assign io_off  = addr[7:1];
  assign ram_idx = addr[AW:1];

  // A misaligned store never writes anything, mapped or not; it only flags.
  assign aligned_wr    = wr & ~addr[0];
  assign misaligned_wr = wr &  addr[0];

  assign wr_out  = aligned_wr & io_hit & (io_off == REG_OUT);
  assign wr_cnt  = aligned_wr & io_hit & (io_off == REG_CNT);
  assign wr_cmp  = aligned_wr & io_hit & (io_off == REG_CMP);
  assign wr_stat = aligned_wr & io_hit & (io_off == REG_STAT);
  assign wr_ram  = aligned_wr & ram_hit;

  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = mem[ram_idx];
    end else if (io_hit) begin
      case (io_off)
        REG_OUT:  rdata = out_r;
        REG_IN:   rdata = in_r;
        REG_CNT:  rdata = cnt;
        REG_CMP:  rdata = cmp;
        REG_STAT: rdata = {14'd0, misalign, match};
        default:  rdata = '0;
      endcase
    end
  end

  // RAM contents survive reset, but a store coinciding with reset is dropped.
  always_ff @(posedge clock) begin
    if (wr_ram && !reset) begin
      mem[ram_idx] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_r    <= '0;
      in_r     <= '0;
      cnt      <= '0;
      cmp      <= '1;
      match    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      in_r <= in_port;
      cnt  <= wr_cnt ? wdata : cnt + 16'd1;
      if (wr_out) out_r <= wdata;
      if (wr_cmp) cmp   <= wdata;
      // Sticky flags: write-1-to-clear, with a same-cycle set taking priority.
      // The compare uses pre-edge CNT and CMP, so a CMP write affects the next cycle.
      match    <= (cnt == cmp) | (match & ~(wr_stat & wdata[0]));
      misalign <= misaligned_wr | (misalign & ~(wr_stat & wdata[1]));
    end
  end

  assign out_port  = out_r;
  assign timer_irq = match;
  assign err       = misalign;

endmodule

// File: tb/tb_vsa16_dmem_io.sv
// Scoreboard bench for vsa16_dmem_io. A stimulus process drives one access
// per cycle and pushes the response a reference model predicts; a monitor on
// the falling edge pops each expectation and compares it against the DUT.
module tb_vsa16_dmem_io;

  localparam int unsigned RAM_WORDS = 128;
  localparam logic [15:0] IO        = 16'hFF00;

  logic        clock;
  logic        reset;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        wr;
  logic [15:0] rdata;
  logic [15:0] in_port;
  logic [15:0] out_port;
  logic        timer_irq;
  logic        err;

  vsa16_dmem_io #(
    .RAM_WORDS(RAM_WORDS),
    .IO_BASE  (IO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .wr       (wr),
    .rdata    (rdata),
    .in_port  (in_port),
    .out_port (out_port),
    .timer_irq(timer_irq),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state.
  logic [15:0] ram [int];
  logic [15:0] m_out, m_in, m_cnt, m_cmp;
  logic        m_match, m_mis;

  typedef struct {
    logic [15:0] rd;
    logic [15:0] op;
    logic        irq;
    logic        er;
    string       lbl;
  } exp_t;

  exp_t q[$];
  int compared   = 0;
  int mismatched = 0;

  function automatic logic [15:0] model_read(input logic [15:0] a);
    int unsigned ua = a;
    if (ua < 2 * RAM_WORDS) return ram.exists(ua / 2) ? ram[ua / 2] : 16'h0000;
    if ((ua / 256) == (IO / 256)) begin
      case ((ua % 256) / 2)
        0: return m_out;
        1: return m_in;
        2: return m_cnt;
        3: return m_cmp;
        4: return {14'd0, m_mis, m_match};
        default: return 16'h0000;
      endcase
    end
    return 16'h0000;
  endfunction

  task automatic model_edge(input logic r, input logic [15:0] a, input logic [15:0] d,
                            input logic w, input logic [15:0] inp);
    int unsigned ua   = a;
    bit          odd  = (ua % 2) == 1;
    bit          alw  = w && !odd;
    int unsigned word = ua - (ua % 2);
    bit          stw  = alw && (word == IO + 8);
    logic [15:0] nc;
    if (r) begin
      m_out = 0; m_in = 0; m_cnt = 0; m_cmp = 16'hFFFF; m_match = 0; m_mis = 0;
      return;
    end
    m_match = (m_cnt == m_cmp) || (m_match && !(stw && d[0]));
    m_mis   = (w && odd) || (m_mis && !(stw && d[1]));
    nc      = (alw && word == IO + 4) ? d : m_cnt + 16'd1;
    m_cnt   = nc;
    if (alw && word == IO + 6) m_cmp = d;
    if (alw && word == IO + 0) m_out = d;
    if (alw && ua < 2 * RAM_WORDS) ram[ua / 2] = d;
    m_in = inp;
  endtask

  // Drive one cycle; called just after a rising edge.
  task automatic step(input logic r, input logic [15:0] a, input logic [15:0] d,
                      input logic w, input logic [15:0] inp, input string lbl);
    exp_t e;
    reset = r; addr = a; wdata = d; wr = w; in_port = inp;
    e.rd = model_read(a); e.op = m_out; e.irq = m_match; e.er = m_mis; e.lbl = lbl;
    q.push_back(e);
    @(posedge clock);
    #1;
    model_edge(r, a, d, w, inp);
  endtask

  function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endfunction

  always @(negedge clock) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.lbl, ".rdata"},     rdata,             e.rd);
      chk({e.lbl, ".out_port"},  out_port,          e.op);
      chk({e.lbl, ".timer_irq"}, {15'd0, timer_irq}, {15'd0, e.irq});
      chk({e.lbl, ".err"},       {15'd0, err},       {15'd0, e.er});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, d;
    int unsigned sel;
    reset = 1'b1; addr = 0; wdata = 0; wr = 0; in_port = 0;
    @(posedge clock);
    #1;
    model_edge(1'b1, 16'h0, 16'h0, 1'b0, 16'h0);

    // Reset state.
    step(0, IO + 6, 0, 0, 0, "rst_cmp");
    step(0, IO + 0, 0, 0, 0, "rst_out");

    // RAM store/load and out-of-range store.
    step(0, 16'h0010, 16'hBEEF, 1, 0, "st_ram");
    step(0, 16'h0010, 0, 0, 0, "ld_ram");
    step(0, 16'h0012, 0, 0, 0, "ld_ram_zero");
    step(0, 16'h0100, 16'h1357, 1, 0, "st_unmapped");
    step(0, 16'h0100, 0, 0, 0, "ld_unmapped");

    // OUT and IN.
    step(0, IO + 0, 16'h00A5, 1, 0, "st_out");
    step(0, IO + 0, 0, 0, 16'h1234, "ld_out");
    step(0, IO + 2, 0, 0, 16'h1234, "ld_in");
    step(0, IO + 2, 16'hFFFF, 1, 16'h1234, "st_in_ignored");
    step(0, IO + 2, 0, 0, 16'h0000, "ld_in2");

    // Timer wrap and match.
    step(0, IO + 4, 16'hFFFE, 1, 0, "st_cnt");
    step(0, IO + 6, 16'h0001, 1, 0, "st_cmp");
    for (int i = 0; i < 5; i++) step(0, IO + 4, 0, 0, 0, "cnt_run");
    step(0, IO + 8, 0, 0, 0, "ld_stat");
    step(0, IO + 8, 16'h0001, 1, 0, "clr_match");
    step(0, IO + 8, 0, 0, 0, "ld_stat_clr");
    // Clear in the very cycle CNT==CMP: set wins.
    step(0, IO + 4, 16'h0001, 1, 0, "st_cnt_eq");
    step(0, IO + 8, 16'h0001, 1, 0, "clr_vs_set");
    step(0, IO + 8, 0, 0, 0, "ld_stat_set");

    // Misaligned stores.
    step(0, 16'h0011, 16'h4444, 1, 0, "st_misal");
    step(0, 16'h0010, 0, 0, 0, "ld_ram_kept");
    step(0, IO + 8, 16'h0002, 1, 0, "clr_misal");
    step(0, IO + 8, 0, 0, 0, "ld_stat_err");
    step(0, 16'h7001, 16'h0001, 1, 0, "st_misal_unmapped");
    step(0, IO + 9, 16'h0002, 1, 0, "st_misal_stat");
    step(0, IO + 8, 0, 0, 0, "ld_stat_misal");

    // Reset mid-count with a simultaneous OUT store.
    step(1, IO + 0, 16'h5555, 1, 16'hAAAA, "rst_with_st");
    step(0, IO + 4, 0, 0, 0, "ld_cnt_after_rst");
    step(0, 16'h0010, 0, 0, 0, "ld_ram_after_rst");
    step(0, IO + 0, 0, 0, 0, "ld_out_after_rst");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 5);
      d   = 16'($urandom);
      case (sel)
        0: a = 16'($urandom_range(0, 2 * RAM_WORDS - 1));
        1: a = IO + 16'($urandom_range(0, 15));
        2: a = 16'($urandom);
        3: a = 16'($urandom_range(2 * RAM_WORDS - 4, 2 * RAM_WORDS + 3));
        4: begin
          a = IO + 16'(2 * $urandom_range(2, 4));
          d = m_cnt + 16'($urandom_range(0, 3));
        end
        default: begin
          a = IO + 8;
          d = 16'($urandom_range(0, 3));
        end
      endcase
      step(($urandom_range(0, 49) == 0), a, d, ($urandom_range(0, 99) < 40),
           16'($urandom), "rand");
    end

    addr = IO + 8; wr = 0; reset = 0;
    @(negedge clock);
    #1;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
